// File: rtl/clock_time_setter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_time_setter: key sync/debounce, inc auto-repeat, BCD edit FSM   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module clock_time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned REPEAT_DELAY    = 13500000,
  parameter int unsigned REPEAT_PERIOD   = 2700000,
  parameter int unsigned TIMEOUT_CYCLES  = 270000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic [1:0] cur_hours_1,
  input  logic [3:0] cur_hours_0,
  input  logic [2:0] cur_minutes_1,
  input  logic [3:0] cur_minutes_0,
  output logic [1:0] set_hours_1,
  output logic [3:0] set_hours_0,
  output logic [2:0] set_minutes_1,
  output logic [3:0] set_minutes_0,
  output logic       load,
  output logic       editing,
  output logic       edit_field
);
  localparam int unsigned KEY_MODE = 0;
  localparam int unsigned KEY_INC  = 1;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_W     = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EDIT_H = 2'd1,
    ST_EDIT_M = 2'd2
  } state_t;

  logic [1:0] key_raw_n;
  logic [1:0] key_stable;
  logic [1:0] key_press;

  assign key_raw_n = {key_inc_n, key_mode_n};

  // Levels are carried as "pressed" (active-high) from the first sync flop on.
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d  = ~key_raw_n[k];
      sync2_d  = sync1_q;
      stable_d = stable_q;
      press_d  = 1'b0;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = sync2_q;
          press_d  = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        press_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= sync1_d;
        sync2_q  <= sync2_d;
        stable_q <= stable_d;
        press_q  <= press_d;
        cnt_q    <= cnt_d;
      end
    end

    assign key_stable[k] = stable_q;
    assign key_press[k]  = press_q;
  end

  function automatic logic [5:0] hours_inc(input logic [1:0] tens, input logic [3:0] units);
    logic [5:0] r;
    if (units > 4'd9 || tens > 2'd2 || (tens == 2'd2 && units >= 4'd3)) r = 6'd0;
    else if (units == 4'd9) r = {tens + 2'd1, 4'd0};
    else r = {tens, units + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] minutes_inc(input logic [2:0] tens, input logic [3:0] units);
    logic [6:0] r;
    if (units > 4'd9 || tens > 3'd5 || (tens == 3'd5 && units == 4'd9)) r = 7'd0;
    else if (units == 4'd9) r = {tens + 3'd1, 4'd0};
    else r = {tens, units + 4'd1};
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      set_hours_1_q, set_hours_1_d;
  logic [3:0]      set_hours_0_q, set_hours_0_d;
  logic [2:0]      set_minutes_1_q, set_minutes_1_d;
  logic [3:0]      set_minutes_0_q, set_minutes_0_d;
  logic            load_q, load_d;
  logic            editing_q, editing_d;
  logic            edit_field_q, edit_field_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic       in_edit, rep_pulse, mode_ev, inc_ev, timeout;
  logic [5:0] hours_next;
  logic [6:0] minutes_next;

  assign hours_next   = hours_inc(set_hours_1_q, set_hours_0_q);
  assign minutes_next = minutes_inc(set_minutes_1_q, set_minutes_0_q);
  assign in_edit      = (state_q != ST_RUN);
  assign rep_pulse    = in_edit && key_stable[KEY_INC] && (rep_cnt_q == RP_W'(REPEAT_DELAY));
  assign mode_ev      = key_press[KEY_MODE];
  assign inc_ev       = key_press[KEY_INC] | rep_pulse;
  assign timeout      = in_edit && !mode_ev && !inc_ev && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // Counter value 0 means idle; after each repeat it reloads so the next lands one period later.
    rep_cnt_d = '0;
    if (in_edit && key_stable[KEY_INC]) begin
      if (key_press[KEY_INC]) rep_cnt_d = RP_W'(1);
      else if (rep_pulse) rep_cnt_d = RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      else if (rep_cnt_q != '0) rep_cnt_d = rep_cnt_q + 1'b1;
    end

    to_cnt_d = '0;
    if (in_edit && !mode_ev && !inc_ev && !timeout) to_cnt_d = to_cnt_q + 1'b1;

    state_d         = state_q;
    set_hours_1_d   = set_hours_1_q;
    set_hours_0_d   = set_hours_0_q;
    set_minutes_1_d = set_minutes_1_q;
    set_minutes_0_d = set_minutes_0_q;
    load_d          = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mode_ev) begin
          state_d         = ST_EDIT_H;
          set_hours_1_d   = cur_hours_1;
          set_hours_0_d   = cur_hours_0;
          set_minutes_1_d = cur_minutes_1;
          set_minutes_0_d = cur_minutes_0;
        end
      end
      ST_EDIT_H: begin
        if (mode_ev) state_d = ST_EDIT_M;
        else if (inc_ev) {set_hours_1_d, set_hours_0_d} = hours_next;
        else if (timeout) state_d = ST_RUN;
      end
      ST_EDIT_M: begin
        if (mode_ev) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (inc_ev) begin
          {set_minutes_1_d, set_minutes_0_d} = minutes_next;
        end else if (timeout) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    editing_d    = (state_d != ST_RUN);
    edit_field_d = (state_d == ST_EDIT_M);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= ST_RUN;
      set_hours_1_q   <= '0;
      set_hours_0_q   <= '0;
      set_minutes_1_q <= '0;
      set_minutes_0_q <= '0;
      load_q          <= 1'b0;
      editing_q       <= 1'b0;
      edit_field_q    <= 1'b0;
      rep_cnt_q       <= '0;
      to_cnt_q        <= '0;
    end else begin
      state_q         <= state_d;
      set_hours_1_q   <= set_hours_1_d;
      set_hours_0_q   <= set_hours_0_d;
      set_minutes_1_q <= set_minutes_1_d;
      set_minutes_0_q <= set_minutes_0_d;
      load_q          <= load_d;
      editing_q       <= editing_d;
      edit_field_q    <= edit_field_d;
      rep_cnt_q       <= rep_cnt_d;
      to_cnt_q        <= to_cnt_d;
    end
  end

  assign set_hours_1   = set_hours_1_q;
  assign set_hours_0   = set_hours_0_q;
  assign set_minutes_1 = set_minutes_1_q;
  assign set_minutes_0 = set_minutes_0_q;
  assign load          = load_q;
  assign editing       = editing_q;
  assign edit_field    = edit_field_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_setter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clock_time_setter: directed stimulus against a behavioural model   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_clock_time_setter;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int TO = 100;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic [1:0] cur_hours_1 = '0;
  logic [3:0] cur_hours_0 = '0;
  logic [2:0] cur_minutes_1 = '0;
  logic [3:0] cur_minutes_0 = '0;
  logic [1:0] set_hours_1;
  logic [3:0] set_hours_0;
  logic [2:0] set_minutes_1;
  logic [3:0] set_minutes_0;
  logic       load, editing, edit_field;

  always #5 sys_clk = ~sys_clk;

  clock_time_setter #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_mode_n   (key_mode_n),
    .key_inc_n    (key_inc_n),
    .cur_hours_1  (cur_hours_1),
    .cur_hours_0  (cur_hours_0),
    .cur_minutes_1(cur_minutes_1),
    .cur_minutes_0(cur_minutes_0),
    .set_hours_1  (set_hours_1),
    .set_hours_0  (set_hours_0),
    .set_minutes_1(set_minutes_1),
    .set_minutes_0(set_minutes_0),
    .load         (load),
    .editing      (editing),
    .edit_field   (edit_field)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int load_count = 0;
  int last_load_h = -1;
  int last_load_m = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dut_hours();
    return int'(set_hours_1) * 10 + int'(set_hours_0);
  endfunction

  function automatic int dut_minutes();
    return int'(set_minutes_1) * 10 + int'(set_minutes_0);
  endfunction

  // Behavioural model: time as whole numbers, keys as raw-sample windows.
  int m_state;          // 0 run, 1 editing hours, 2 editing minutes
  int m_h1, m_h0, m_m1, m_m0;
  bit m_load;
  bit m_hist [2][D+2];  // [0] = newest raw sample (pressed = 1)
  bit m_st [2];
  bit m_pr [2];
  bit m_rep_act;
  int m_rep_k;
  int m_idle;
  bit mv_mode_ev, mv_inc_ev, mv_rep_ev, mv_was_edit, mv_diff, mv_raw;
  int mv_v;

  always @(posedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      m_state = 0; m_h1 = 0; m_h0 = 0; m_m1 = 0; m_m0 = 0; m_load = 0;
      m_rep_act = 0; m_rep_k = 0; m_idle = 0;
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_pr[k] = 0;
        for (int j = 0; j < D + 2; j++) m_hist[k][j] = 0;
      end
    end else begin
      mv_was_edit = (m_state != 0);
      mv_rep_ev = mv_was_edit && m_rep_act && m_st[1] && m_rep_k >= RD && ((m_rep_k - RD) % RP) == 0;
      mv_mode_ev = m_pr[0];
      mv_inc_ev = m_pr[1] || mv_rep_ev;
      m_load = 0;
      if (m_state == 0) begin
        m_idle = 0;
        if (mv_mode_ev) begin
          m_state = 1;
          m_h1 = cur_hours_1; m_h0 = cur_hours_0; m_m1 = cur_minutes_1; m_m0 = cur_minutes_0;
        end
      end else if (mv_mode_ev) begin
        m_idle = 0;
        if (m_state == 1) m_state = 2;
        else begin m_state = 0; m_load = 1; end
      end else if (mv_inc_ev) begin
        m_idle = 0;
        if (m_state == 1) begin
          mv_v = m_h1 * 10 + m_h0;
          mv_v = (m_h0 > 9 || mv_v > 23) ? 0 : (mv_v + 1) % 24;
          m_h1 = mv_v / 10; m_h0 = mv_v % 10;
        end else begin
          mv_v = m_m1 * 10 + m_m0;
          mv_v = (m_m0 > 9 || m_m1 > 5) ? 0 : (mv_v + 1) % 60;
          m_m1 = mv_v / 10; m_m0 = mv_v % 10;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_state = 0; m_idle = 0; end
      end

      if (m_pr[1] && mv_was_edit) begin m_rep_act = 1; m_rep_k = 1; end
      else if (m_rep_act && m_st[1] && mv_was_edit) m_rep_k++;
      else m_rep_act = 0;

      for (int k = 0; k < 2; k++) begin
        mv_raw = (k == 0) ? !key_mode_n : !key_inc_n;
        for (int j = D + 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = mv_raw;
        m_pr[k] = 0;
        mv_diff = 1;
        for (int j = 2; j < D + 2; j++) if (m_hist[k][j] == m_st[k]) mv_diff = 0;
        if (mv_diff) begin
          m_st[k] = !m_st[k];
          m_pr[k] = m_st[k];
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (cyc > 0) begin
      chk("editing", int'(editing), int'(m_state != 0));
      if (m_state != 0) chk("edit_field", int'(edit_field), int'(m_state == 2));
      chk("load", int'(load), int'(m_load));
      chk("set_hours_1", int'(set_hours_1), m_h1);
      chk("set_hours_0", int'(set_hours_0), m_h0);
      chk("set_minutes_1", int'(set_minutes_1), m_m1);
      chk("set_minutes_0", int'(set_minutes_0), m_m0);
      if (load) begin
        load_count++;
        last_load_h = dut_hours();
        last_load_m = dut_minutes();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press(input bit mode, input bit inc, input int hold);
    if (mode) key_mode_n = 1'b0;
    if (inc) key_inc_n = 1'b0;
    tick(hold);
    key_mode_n = 1'b1;
    key_inc_n = 1'b1;
    tick(10);
  endtask

  task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
    cur_hours_1 = 2'(h1); cur_hours_0 = 4'(h0);
    cur_minutes_1 = 3'(m1); cur_minutes_0 = 4'(m0);
  endtask

  int t_last;
  int rise;
  int loads_before;

  initial begin
    tick(3);
    sys_rst = 1'b0;
    tick(2);
    chk("reset_editing", int'(editing), 0);
    chk("reset_load", int'(load), 0);
    chk("reset_set", dut_hours() * 100 + dut_minutes(), 0);

    // Full edit sequence 12:34 -> 14:35
    set_cur(1, 2, 3, 4);
    press(1, 0, 10);
    chk("full_enter_editing", int'(editing), 1);
    chk("full_capture", dut_hours() * 100 + dut_minutes(), 1234);
    press(0, 1, 10);
    press(0, 1, 10);
    chk("full_hours", dut_hours(), 14);
    press(1, 0, 10);
    chk("full_field_min", int'(edit_field), 1);
    press(0, 1, 10);
    chk("full_minutes", dut_minutes(), 35);
    press(1, 0, 10);
    chk("full_load_count", load_count, 1);
    chk("full_load_value", last_load_h * 100 + last_load_m, 1435);
    chk("full_exit_editing", int'(editing), 0);

    // Bounce rejection: 2-cycle chatter, then a clean hold
    set_cur(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      key_mode_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(2);
    end
    key_mode_n = 1'b0;
    t_last = cyc + 1;
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (i == 9) key_mode_n = 1'b1;
      if (editing && rise < 0) rise = cyc;
    end
    chk("bounce_rise_cycle", rise, t_last + 6);
    press(1, 0, 10);
    press(1, 0, 10);
    chk("bounce_single_load", load_count, 2);

    // Wrap 23:59 -> 00:00
    set_cur(2, 3, 5, 9);
    press(1, 0, 10);
    press(0, 1, 10);
    chk("wrap_hours", dut_hours(), 0);
    press(1, 0, 10);
    press(0, 1, 10);
    press(1, 0, 10);
    chk("wrap_load_value", last_load_h * 100 + last_load_m, 0);

    // Non-canonical hours 3:9 -> 00
    set_cur(3, 9, 1, 0);
    press(1, 0, 10);
    press(0, 1, 10);
    chk("noncanon_hours", dut_hours(), 0);
    press(1, 0, 10);
    press(1, 0, 10);

    // Auto-repeat from 00 in minutes
    set_cur(0, 0, 0, 0);
    press(1, 0, 10);
    press(1, 0, 10);
    press(0, 1, 50);
    chk("repeat_minutes", dut_minutes(), 7);
    press(1, 0, 10);
    chk("repeat_load_value", last_load_h * 100 + last_load_m, 7);

    // Timeout abort
    loads_before = load_count;
    press(1, 0, 10);
    chk("timeout_enter", int'(editing), 1);
    tick(110);
    chk("timeout_exit", int'(editing), 0);
    chk("timeout_no_load", load_count, loads_before);

    // Simultaneous mode and inc in hours edit
    set_cur(0, 8, 1, 5);
    press(1, 0, 10);
    press(1, 1, 10);
    chk("simul_field", int'(edit_field), 1);
    chk("simul_hours", dut_hours(), 8);
    press(1, 0, 10);
    chk("simul_load_value", last_load_h * 100 + last_load_m, 815);

    // Reset in the middle of a minutes edit
    set_cur(0, 5, 1, 7);
    press(1, 0, 10);
    press(1, 0, 10);
    press(0, 1, 10);
    chk("rst_pre_minutes", dut_minutes(), 18);
    loads_before = load_count;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_editing", int'(editing), 0);
    chk("rst_set", dut_hours() * 100 + dut_minutes(), 0);
    tick(20);
    chk("rst_no_load", load_count, loads_before);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
